// File: rtl/mux_select_unit.sv
// mux_select_unit: a 2:1 and a 4:1 multiplexer, each with a combinational
// result and a registered copy that loads under a shared enable. qv flags
// that the registered copies hold data loaded since the last reset.
module mux_select_unit #(
  parameter int W2 = 5,
  parameter int W4 = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          s2,
  input  logic [W2-1:0] a2,
  input  logic [W2-1:0] b2,
  input  logic [1:0]    s4,
  input  logic [W4-1:0] a4,
  input  logic [W4-1:0] b4,
  input  logic [W4-1:0] c4,
  input  logic [W4-1:0] d4,
  output logic [W2-1:0] y2,
  output logic [W4-1:0] y4,
  output logic [W2-1:0] q2,
  output logic [W4-1:0] q4,
  output logic          qv
);

  logic [W2-1:0] w_y2;
  logic [W4-1:0] w_y4;
  logic [W2-1:0] r_q2;
  logic [W4-1:0] r_q4;
  logic          r_qv;

  // 2:1 select; an unknown select falls through to the all-zero default
  always_comb begin
    w_y2 = '0;
    case (s2)
      1'b0:    w_y2 = a2;
      1'b1:    w_y2 = b2;
      default: w_y2 = '0;
    endcase
  end

  // 4:1 select; unknown or unmatched select yields all-zero
  always_comb begin
    w_y4 = '0;
    case (s4)
      2'b00:   w_y4 = a4;
      2'b01:   w_y4 = b4;
      2'b10:   w_y4 = c4;
      2'b11:   w_y4 = d4;
      default: w_y4 = '0;
    endcase
  end

  // Registered copies: async clear, load on enabled edges, otherwise hold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q2 <= '0;
      r_q4 <= '0;
      r_qv <= 1'b0;
    end else if (en) begin
      r_q2 <= w_y2;
      r_q4 <= w_y4;
      r_qv <= 1'b1;
    end
  end

  assign y2 = w_y2;
  assign y4 = w_y4;
  assign q2 = r_q2;
  assign q4 = r_q4;
  assign qv = r_qv;

endmodule

// File: tb/tb_mux_select_unit.sv
// Self-checking bench for mux_select_unit: directed scenarios plus a
// randomized run, all compared against a behavioural model.
module tb_mux_select_unit;
  localparam int W2 = 5;
  localparam int W4 = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          s2;
  logic [W2-1:0] a2, b2;
  logic [1:0]    s4;
  logic [W4-1:0] a4, b4, c4, d4;
  logic [W2-1:0] y2, q2;
  logic [W4-1:0] y4, q4;
  logic          qv;

  int checks   = 0;
  int failures = 0;

  // Model of the registered state
  logic [W2-1:0] m_q2;
  logic [W4-1:0] m_q4;
  logic          m_qv;

  mux_select_unit #(.W2(W2), .W4(W4)) dut (
    .clk(clk), .rst(rst), .en(en),
    .s2(s2), .a2(a2), .b2(b2),
    .s4(s4), .a4(a4), .b4(b4), .c4(c4), .d4(d4),
    .y2(y2), .y4(y4), .q2(q2), .q4(q4), .qv(qv)
  );

  always #5 clk = ~clk;

  function automatic logic [W2-1:0] ref2();
    if ($isunknown(s2)) return '0;
    return s2 ? b2 : a2;
  endfunction

  function automatic logic [W4-1:0] ref4();
    logic [W4-1:0] tbl [4];
    tbl[0] = a4; tbl[1] = b4; tbl[2] = c4; tbl[3] = d4;
    if ($isunknown(s4)) return '0;
    return tbl[s4];
  endfunction

  // Advance one rising edge and update the model; returns 1 ns after the edge
  task automatic tick();
    logic [W2-1:0] n2;
    logic [W4-1:0] n4;
    logic          load;
    load = (rst === 1'b1) && (en === 1'b1);
    n2 = ref2();
    n4 = ref4();
    @(posedge clk);
    if (load) begin
      m_q2 = n2; m_q4 = n4; m_qv = 1'b1;
    end
    if (rst !== 1'b1) begin
      m_q2 = '0; m_q4 = '0; m_qv = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b1; s2 = 1'b0; s4 = 2'b00;
    a2 = 5'h0A; b2 = 5'h15; a4 = 32'hDEADBEEF; b4 = '0; c4 = '0; d4 = '0;
    m_q2 = '0; m_q4 = '0; m_qv = 1'b0;
    tick(); tick();
    checks++;
    if (q2 !== '0 || q4 !== '0 || qv !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: q2=%h q4=%h qv=%b required 0/0/0", q2, q4, qv);
    end
    checks++;
    if (y2 !== 5'h0A || y4 !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL reset_comb: y2=%h y4=%h required 0a/deadbeef", y2, y4);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  task automatic test_sweep2();
    en = 1'b1; a2 = 5'h03; b2 = 5'h1C; s2 = 1'b0;
    #1;
    checks++;
    if (y2 !== 5'h03) begin
      failures++; $display("FAIL sweep2_y_a: y2=%h required 03", y2);
    end
    tick();
    checks++;
    if (q2 !== 5'h03 || qv !== 1'b1) begin
      failures++; $display("FAIL sweep2_q_a: q2=%h qv=%b required 03/1", q2, qv);
    end
    s2 = 1'b1;
    #1;
    checks++;
    if (y2 !== 5'h1C || q2 !== 5'h03) begin
      failures++; $display("FAIL sweep2_y_b: y2=%h q2=%h required 1c/03", y2, q2);
    end
    tick();
    checks++;
    if (q2 !== 5'h1C) begin
      failures++; $display("FAIL sweep2_q_b: q2=%h required 1c", q2);
    end
  endtask

  task automatic test_sweep4();
    logic [W4-1:0] vals [4];
    vals[0] = 32'h11111111; vals[1] = 32'h22222222;
    vals[2] = 32'h33333333; vals[3] = 32'h44444444;
    a4 = vals[0]; b4 = vals[1]; c4 = vals[2]; d4 = vals[3];
    en = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      s4 = 2'(i);
      #1;
      checks++;
      if (y4 !== vals[i]) begin
        failures++; $display("FAIL sweep4_y[%0d]: y4=%h required %h", i, y4, vals[i]);
      end
      tick();
      checks++;
      if (q4 !== vals[i]) begin
        failures++; $display("FAIL sweep4_q[%0d]: q4=%h required %h", i, q4, vals[i]);
      end
    end
  endtask

  task automatic test_hold();
    en = 1'b1; s4 = 2'b10; c4 = 32'h33333333;
    tick();
    en = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      s4 = 2'($urandom_range(0, 3));
      a4 = $urandom; b4 = $urandom; c4 = $urandom; d4 = $urandom;
      s2 = 1'($urandom); a2 = 5'($urandom);
      #1;
      checks++;
      if (y4 !== ref4() || y2 !== ref2()) begin
        failures++;
        $display("FAIL hold_y[%0d]: y4=%h y2=%h required %h/%h", i, y4, y2, ref4(), ref2());
      end
      tick();
      checks++;
      if (q4 !== 32'h33333333 || qv !== 1'b1) begin
        failures++; $display("FAIL hold_q[%0d]: q4=%h qv=%b required 33333333/1", i, q4, qv);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [W2-1:0] hy2;
    logic [W4-1:0] hy4;
    en = 1'b1; s2 = 1'b1; b2 = 5'h11; s4 = 2'b01; b4 = 32'hCAFEF00D;
    tick();
    #2;
    hy2 = y2; hy4 = y4;
    rst = 1'b0;
    m_q2 = '0; m_q4 = '0; m_qv = 1'b0;
    #1;
    checks++;
    if (q2 !== '0 || q4 !== '0 || qv !== 1'b0) begin
      failures++; $display("FAIL async_clear: q2=%h q4=%h qv=%b required 0/0/0", q2, q4, qv);
    end
    checks++;
    if (y2 !== hy2 || y4 !== hy4 || y2 !== 5'h11 || y4 !== 32'hCAFEF00D) begin
      failures++; $display("FAIL async_comb: y2=%h y4=%h required 11/cafef00d", y2, y4);
    end
    tick(); tick();
    checks++;
    if (q2 !== '0 || q4 !== '0 || qv !== 1'b0) begin
      failures++; $display("FAIL reset_held: q2=%h q4=%h qv=%b required 0/0/0", q2, q4, qv);
    end
    en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick();
    checks++;
    if (qv !== 1'b0 || q4 !== '0) begin
      failures++; $display("FAIL post_reset_noen: qv=%b q4=%h required 0/0", qv, q4);
    end
    en = 1'b1;
    tick();
    checks++;
    if (qv !== 1'b1 || q4 !== 32'hCAFEF00D) begin
      failures++; $display("FAIL post_reset_load: qv=%b q4=%h required 1/cafef00d", qv, q4);
    end
  endtask

  task automatic test_xselect();
    en = 1'b1;
    a4 = 32'hA5A5A5A5; b4 = 32'h5A5A5A5A; c4 = 32'h0F0F0F0F; d4 = 32'hF0F0F0F0;
    s4 = 2'bxx;
    #1;
    checks++;
    if (y4 !== ref4()) begin
      failures++; $display("FAIL xsel_y: y4=%h required %h", y4, ref4());
    end
    tick();
    checks++;
    if (q4 !== m_q4) begin
      failures++; $display("FAIL xsel_q: q4=%h required %h", q4, m_q4);
    end
    s4 = 2'b00;
    #1;
  endtask

  task automatic test_reset_release();
    en = 1'b1; s2 = 1'b0; a2 = 5'h07; s4 = 2'b11; d4 = 32'h44444444;
    @(negedge clk);
    rst = 1'b0;
    m_q2 = '0; m_q4 = '0; m_qv = 1'b0;
    @(posedge clk);
    rst <= 1'b1;  // released in the same time step as the edge, after it is sampled
    #1;
    checks++;
    if (qv !== 1'b0 || q2 !== '0 || q4 !== '0) begin
      failures++; $display("FAIL release_edge: qv=%b q2=%h q4=%h required 0/0/0", qv, q2, q4);
    end
    tick();
    checks++;
    if (qv !== 1'b1 || q2 !== 5'h07 || q4 !== 32'h44444444) begin
      failures++; $display("FAIL release_next: qv=%b q2=%h q4=%h required 1/07/44444444", qv, q2, q4);
    end
  endtask

  task automatic test_random();
    for (int unsigned i = 0; i < 40; i++) begin
      en = 1'($urandom); s2 = 1'($urandom); s4 = 2'($urandom);
      a2 = 5'($urandom); b2 = 5'($urandom);
      a4 = $urandom; b4 = $urandom; c4 = $urandom; d4 = $urandom;
      #1;
      checks++;
      if (y2 !== ref2() || y4 !== ref4()) begin
        failures++;
        $display("FAIL rand_y[%0d]: y2=%h y4=%h required %h/%h", i, y2, y4, ref2(), ref4());
      end
      tick();
      checks++;
      if (q2 !== m_q2 || q4 !== m_q4 || qv !== m_qv) begin
        failures++;
        $display("FAIL rand_q[%0d]: q2=%h q4=%h qv=%b required %h/%h/%b",
                 i, q2, q4, qv, m_q2, m_q4, m_qv);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sweep2();
    test_sweep4();
    test_hold();
    test_async_reset();
    test_xselect();
    test_reset_release();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
